// File: rtl/core_pkg.sv
// Shared definitions for the core instruction path: inst bit positions,
// the idle instruction word and the sequencer state encoding.
package core_pkg;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;

  localparam int BIT_LOAD     = 0;
  localparam int BIT_EXECUTE  = 1;
  localparam int BIT_L0_WR    = 2;
  localparam int BIT_L0_RD    = 3;
  localparam int BIT_IFIFO_RD = 4;
  localparam int BIT_IFIFO_WR = 5;
  localparam int BIT_OFIFO_RD = 6;
  localparam int A_XMEM_LSB   = 7;
  localparam int BIT_WEN_XMEM = 18;
  localparam int BIT_CEN_XMEM = 19;
  localparam int A_PMEM_LSB   = 20;
  localparam int BIT_WEN_PMEM = 31;
  localparam int BIT_CEN_PMEM = 32;
  localparam int BIT_ACC      = 33;

  // Both memories deselected with write disabled; every strobe low.
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_WFLUSH = 3'd2,
    S_EXEC   = 3'd3,
    S_FLUSH  = 3'd4,
    S_ACC    = 3'd5,
    S_OREAD  = 3'd6,
    S_DONE   = 3'd7
  } seq_state_e;

endpackage

// File: rtl/core_inst_seq.sv
// Convolution instruction sequencer: steps the core through weight load,
// execute, flush and psum accumulate per kernel offset, then drains the OFIFO.
module core_inst_seq
  import core_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int LEN_KIJ = 9,
  parameter int LEN_NIJ = 36,
  parameter int W_BASE  = 1024,
  parameter int A_BASE  = 0,
  parameter int P_BASE  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij,
  output seq_state_e        dbg_state
);

  // Handshake: ofifo_rd is asserted only when ofifo_valid was seen high, so
  // every cycle with ofifo_rd=1 in inst is one completed OFIFO pop.

  // cnt value on the final cycle of each timed state
  localparam logic [15:0] WLOAD_LAST  = 16'(row);
  localparam logic [15:0] WFLUSH_LAST = 16'(row - 1);
  localparam logic [15:0] EXEC_LAST   = 16'(LEN_NIJ);
  localparam logic [15:0] FLUSH_LAST  = 16'(row + col - 1);
  localparam logic [15:0] ACC_LAST    = 16'(2 * LEN_NIJ - 1);
  localparam logic [3:0]  KIJ_LAST    = 4'(LEN_KIJ - 1);
  localparam logic [10:0] POPS_TOTAL  = 11'(LEN_NIJ);

  seq_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [3:0]        kij_q, kij_d;
  logic [10:0]       pops_q, pops_d;
  logic              rd_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              busy_q, done_q;

  // inst is built from the upcoming state so the registered word lines up
  // with the state/cnt it describes.
  function automatic logic [INST_W-1:0] next_inst(input seq_state_e s,
                                                  input logic [15:0] c,
                                                  input logic [3:0] k,
                                                  input logic rd);
    logic [INST_W-1:0] i;
    logic [31:0]       a;
    i = IDLE_INST;
    a = '0;
    case (s)
      S_WLOAD: begin
        if (c < WLOAD_LAST) begin
          a = 32'(W_BASE) + 32'(k) * 32'(row) + 32'(c);
          i[BIT_CEN_XMEM] = 1'b0;
          i[A_XMEM_LSB +: ADDR_W] = a[ADDR_W-1:0];
        end
        if (c != 16'd0) begin
          i[BIT_L0_WR] = 1'b1;
          i[BIT_LOAD]  = 1'b1;
        end
      end
      S_EXEC: begin
        if (c < EXEC_LAST) begin
          a = 32'(A_BASE) + 32'(c);
          i[BIT_CEN_XMEM] = 1'b0;
          i[A_XMEM_LSB +: ADDR_W] = a[ADDR_W-1:0];
        end
        if (c != 16'd0) begin
          i[BIT_IFIFO_WR] = 1'b1;
          i[BIT_EXECUTE]  = 1'b1;
        end
      end
      S_ACC: begin
        // even cnt reads psum n, odd cnt writes it back
        a = 32'(P_BASE) + 32'(c[15:1]);
        i[BIT_CEN_PMEM] = 1'b0;
        i[A_PMEM_LSB +: ADDR_W] = a[ADDR_W-1:0];
        if (c[0]) begin
          i[BIT_WEN_PMEM] = 1'b0;
          i[BIT_ACC]      = (k != 4'd0);
        end
      end
      S_OREAD: i[BIT_OFIFO_RD] = rd;
      default: ;
    endcase
    return i;
  endfunction

  always_comb begin
    state_d = state_q;
    kij_d   = kij_q;
    cnt_d   = cnt_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_WLOAD;
          kij_d   = '0;
        end
      end
      S_WLOAD: if (cnt_q == WLOAD_LAST) begin
        state_d = S_WFLUSH;
        cnt_d   = '0;
      end
      S_WFLUSH: if (cnt_q == WFLUSH_LAST) begin
        state_d = S_EXEC;
        cnt_d   = '0;
      end
      S_EXEC: if (cnt_q == EXEC_LAST) begin
        state_d = S_FLUSH;
        cnt_d   = '0;
      end
      S_FLUSH: if (cnt_q == FLUSH_LAST) begin
        state_d = S_ACC;
        cnt_d   = '0;
      end
      S_ACC: if (cnt_q == ACC_LAST) begin
        cnt_d = '0;
        if (kij_q != KIJ_LAST) begin
          kij_d   = kij_q + 4'd1;
          state_d = S_WLOAD;
        end else begin
          state_d = S_OREAD;
        end
      end
      S_OREAD: begin
        cnt_d = '0;
        if (pops_q == POPS_TOTAL) state_d = S_DONE;
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    rd_d   = (state_d == S_OREAD) && (pops_q != POPS_TOTAL) && ofifo_valid;
    pops_d = (state_d == S_OREAD) ? pops_q + 11'(rd_d) : '0;
    inst_d = next_inst(state_d, cnt_d, kij_d, rd_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      pops_q  <= '0;
      inst_q  <= IDLE_INST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      pops_q  <= pops_d;
      inst_q  <= inst_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign inst      = inst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign kij       = kij_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: reset checks, a vector table over a recorded run,
// and randomized runs compared cycle by cycle against a loop-built model.
module tb_core_inst_seq;
  import core_pkg::*;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int LK  = 2;
  localparam int LN  = 4;
  localparam int WB  = 1024;
  localparam int AB  = 0;
  localparam int PB  = 0;
  localparam int PER_KIJ = (ROW + 1) + ROW + (LN + 1) + (ROW + COL) + 2 * LN;
  localparam int T_OREAD = LK * PER_KIJ;
  localparam int TR_LEN  = T_OREAD + 64;
  localparam logic [33:0] IDLE = 34'h1_800C_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;
  seq_state_e  dbg_state;

  always #5 clk = ~clk;

  core_inst_seq #(
    .row(ROW), .col(COL), .LEN_KIJ(LK), .LEN_NIJ(LN),
    .W_BASE(WB), .A_BASE(AB), .P_BASE(PB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .kij(kij), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];
  logic [3:0]  exp_kij_q[$];
  logic [33:0] tr_inst [TR_LEN];
  logic [3:0]  tr_kij [TR_LEN];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] mk(input bit load, input bit exe, input bit l0wr,
                                     input bit ifwr, input bit ofrd, input int ax,
                                     input bit wenx, input bit cenx, input int ap,
                                     input bit wenp, input bit cenp, input bit acc);
    logic [33:0] v;
    v = '0;
    v[0] = load; v[1] = exe; v[2] = l0wr; v[5] = ifwr; v[6] = ofrd;
    v[17:7] = ax[10:0]; v[18] = wenx; v[19] = cenx;
    v[30:20] = ap[10:0]; v[31] = wenp; v[32] = cenp; v[33] = acc;
    return v;
  endfunction

  // Expected inst stream from the first WLOAD cycle up to OREAD entry.
  task automatic build_model();
    exp_q.delete();
    exp_kij_q.delete();
    for (int k = 0; k < LK; k++) begin
      for (int c = 0; c <= ROW; c++) begin
        exp_q.push_back(mk(c > 0, 0, c > 0, 0, 0, (c < ROW) ? WB + k * ROW + c : 0,
                           1, c >= ROW, 0, 1, 1, 0));
        exp_kij_q.push_back(4'(k));
      end
      for (int c = 0; c < ROW; c++) begin
        exp_q.push_back(IDLE); exp_kij_q.push_back(4'(k));
      end
      for (int c = 0; c <= LN; c++) begin
        exp_q.push_back(mk(0, c > 0, 0, c > 0, 0, (c < LN) ? AB + c : 0,
                           1, c >= LN, 0, 1, 1, 0));
        exp_kij_q.push_back(4'(k));
      end
      for (int c = 0; c < ROW + COL; c++) begin
        exp_q.push_back(IDLE); exp_kij_q.push_back(4'(k));
      end
      for (int n = 0; n < LN; n++) begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, PB + n, 1, 0, 0));
        exp_kij_q.push_back(4'(k));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, PB + n, 0, 0, k > 0));
        exp_kij_q.push_back(4'(k));
      end
    end
  endtask

  // ---------------- driver ----------------
  // One run from start to the IDLE cycle after DONE. abort_at >= 0 applies
  // reset after that cycle; poke sprays start while busy; use_pat drives the
  // fixed 1,0,1,0,1,1 ofifo_valid pattern into OREAD.
  task automatic do_run(input int abort_at, input bit poke, input bit use_pat,
                        input bit record, output int done_seen);
    bit   pat [6];
    int   t, pops, done_at;
    bit   prev_v, v, fin;
    logic [33:0] e_inst;
    logic e_busy, e_done;
    pat = '{1, 0, 1, 0, 1, 1};
    t = 0; pops = 0; done_at = -1; prev_v = 0; fin = 0; done_seen = -1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!fin) begin
      @(negedge clk);
      e_busy = 1'b1;
      e_done = 1'b0;
      if (t < T_OREAD) begin
        e_inst = exp_q[t];
        chk($sformatf("kij t=%0d", t), 64'(kij), 64'(exp_kij_q[t]));
      end else if (done_at < 0) begin
        e_inst = IDLE;
        e_inst[6] = prev_v;
        if (prev_v) pops++;
        if (pops == LN) done_at = t + 1;
      end else if (t == done_at) begin
        e_inst = IDLE;
        e_done = 1'b1;
        done_seen = t;
      end else begin
        e_inst = IDLE;
        e_busy = 1'b0;
        fin = 1;
      end
      chk($sformatf("inst t=%0d", t), 64'(inst), 64'(e_inst));
      chk($sformatf("busy t=%0d", t), 64'(busy), 64'(e_busy));
      chk($sformatf("done t=%0d", t), 64'(done), 64'(e_done));
      if (record && t < TR_LEN) begin
        tr_inst[t] = inst;
        tr_kij[t]  = kij;
      end
      if (use_pat && t >= T_OREAD - 1 && t < T_OREAD + 5) v = pat[t - (T_OREAD - 1)];
      else v = 1'($urandom_range(0, 1));
      ofifo_valid = v;
      prev_v = v;
      start = (poke && t < T_OREAD && $urandom_range(0, 2) == 0);
      if (t == abort_at) begin
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort inst", 64'(inst), 64'(IDLE));
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort kij", 64'(kij), 64'd0);
        reset = 1'b0;
        fin = 1;
      end
      t++;
      if (!fin && t > 3000) begin
        chk("run timeout", 64'(t), 64'(T_OREAD));
        fin = 1;
      end
    end
    start = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          t;
    logic [33:0] inst;
    logic [3:0]  kij;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int done_seen;
    int exec_cnt;
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    build_model();

    tbl.push_back('{0,  mk(0, 0, 0, 0, 0, 1024, 1, 0, 0, 1, 1, 0), 4'd0});
    tbl.push_back('{7,  mk(1, 0, 1, 0, 0, 1031, 1, 0, 0, 1, 1, 0), 4'd0});
    tbl.push_back('{8,  mk(1, 0, 1, 0, 0, 0,    1, 1, 0, 1, 1, 0), 4'd0});
    tbl.push_back('{9,  IDLE, 4'd0});
    tbl.push_back('{17, mk(0, 0, 0, 0, 0, 0,    1, 0, 0, 1, 1, 0), 4'd0});
    tbl.push_back('{18, mk(0, 1, 0, 1, 0, 1,    1, 0, 0, 1, 1, 0), 4'd0});
    tbl.push_back('{21, mk(0, 1, 0, 1, 0, 0,    1, 1, 0, 1, 1, 0), 4'd0});
    tbl.push_back('{22, IDLE, 4'd0});
    tbl.push_back('{37, IDLE, 4'd0});
    tbl.push_back('{38, mk(0, 0, 0, 0, 0, 0,    1, 1, 0, 1, 0, 0), 4'd0});
    tbl.push_back('{39, mk(0, 0, 0, 0, 0, 0,    1, 1, 0, 0, 0, 0), 4'd0});
    tbl.push_back('{45, mk(0, 0, 0, 0, 0, 0,    1, 1, 3, 0, 0, 0), 4'd0});
    tbl.push_back('{46, mk(0, 0, 0, 0, 0, 1032, 1, 0, 0, 1, 1, 0), 4'd1});
    tbl.push_back('{53, mk(1, 0, 1, 0, 0, 1039, 1, 0, 0, 1, 1, 0), 4'd1});
    tbl.push_back('{85, mk(0, 0, 0, 0, 0, 0,    1, 1, 0, 0, 0, 1), 4'd1});
    tbl.push_back('{91, mk(0, 0, 0, 0, 0, 0,    1, 1, 3, 0, 0, 1), 4'd1});

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset inst", 64'(inst), 64'(IDLE));
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset kij", 64'(kij), 64'd0);
    chk("reset state", 64'(dbg_state), 64'(S_IDLE));

    // start together with reset: reset wins
    start = 1'b1;
    @(negedge clk);
    chk("start+reset busy", 64'(busy), 64'd0);
    chk("start+reset inst", 64'(inst), 64'(IDLE));
    start = 1'b0;
    reset = 1'b0;

    // idle with start low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ofifo_valid = 1'($urandom_range(0, 1));
      chk($sformatf("idle inst %0d", i), 64'(inst), 64'(IDLE));
      chk($sformatf("idle busy %0d", i), 64'(busy), 64'd0);
    end

    // run 1: recorded, fixed OREAD pattern
    do_run(-1, 1'b0, 1'b1, 1'b1, done_seen);
    chk("done after 4th pop", 64'(done_seen), 64'(T_OREAD + 6));
    foreach (tbl[i]) begin
      chk($sformatf("tbl inst t=%0d", tbl[i].t), 64'(tr_inst[tbl[i].t]), 64'(tbl[i].inst));
      chk($sformatf("tbl kij t=%0d", tbl[i].t), 64'(tr_kij[tbl[i].t]), 64'(tbl[i].kij));
    end
    exec_cnt = 0;
    for (int i = 0; i < PER_KIJ; i++) exec_cnt += int'(tr_inst[i][1]);
    chk("execute cycles kij0", 64'(exec_cnt), 64'(LN));

    // run 2: start pulses while busy, random ofifo_valid
    do_run(-1, 1'b1, 1'b0, 1'b0, done_seen);

    // run 3: reset on EXEC cycle 2, then a fresh run from kij=0
    do_run(17 + 2, 1'b0, 1'b0, 1'b0, done_seen);
    do_run(-1, 1'b0, 1'b0, 1'b0, done_seen);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
